// File: rtl/instr_sequencer.sv
// SAP-1 instruction register and T-state sequencer with a Moore control word.
// Optional SEQ_EARLY_END_EN: each instruction returns to T1 after its last active state.
module instr_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bus,
    output logic [7:0] ir_out,
    output logic [3:0] opcode,
    output logic [2:0] tstate,
    output logic       pc_en,
    output logic       pc_inc,
    output logic       mar_load,
    output logic       mem_en,
    output logic       ir_load,
    output logic       ir_en,
    output logic       a_load,
    output logic       a_en,
    output logic       b_load,
    output logic       alu_en,
    output logic       alu_sub,
    output logic       out_load,
    output logic       hlt
);

    localparam logic [2:0] T1   = 3'd0;
    localparam logic [2:0] T2   = 3'd1;
    localparam logic [2:0] T3   = 3'd2;
    localparam logic [2:0] T4   = 3'd3;
    localparam logic [2:0] T5   = 3'd4;
    localparam logic [2:0] T6   = 3'd5;
    localparam logic [2:0] HALT = 3'd6;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [7:0] r_ir;
    logic [3:0] w_op;
    logic       w_t4_last;
    logic       w_t5_last;

    assign w_op   = r_ir[7:4];
    assign opcode = w_op;
    assign tstate = r_state;
    assign ir_out = {4'b0000, r_ir[3:0]};

`ifdef SEQ_EARLY_END_EN
    logic w_nop;
    assign w_nop = (w_op != OP_LDA) && (w_op != OP_ADD) &&
                   (w_op != OP_SUB) && (w_op != OP_OUT) &&
                   (w_op != OP_HLT);
    assign w_t4_last = (w_op == OP_OUT) || w_nop;
    assign w_t5_last = (w_op == OP_LDA);
`else
    assign w_t4_last = 1'b0;
    assign w_t5_last = 1'b0;
`endif

    // Timing ring: step through T-states, HLT parks in HALT.
    always_comb begin
        w_next = T1;
        case (r_state)
            T1:      w_next = T2;
            T2:      w_next = T3;
            T3:      w_next = T4;
            T4: begin
                if (w_op == OP_HLT)
                    w_next = HALT;
                else if (w_t4_last)
                    w_next = T1;
                else
                    w_next = T5;
            end
            T5:      w_next = w_t5_last ? T1 : T6;
            T6:      w_next = T1;
            HALT:    w_next = HALT;
            default: w_next = T1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= T1;
        else
            r_state <= w_next;
    end

    // Instruction register: captures the bus only while ir_load is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ir <= 8'h00;
        else if (ir_load)
            r_ir <= bus;
    end

    // Moore control word decoded from state and opcode.
    always_comb begin
        pc_en    = 1'b0;
        pc_inc   = 1'b0;
        mar_load = 1'b0;
        mem_en   = 1'b0;
        ir_load  = 1'b0;
        ir_en    = 1'b0;
        a_load   = 1'b0;
        a_en     = 1'b0;
        b_load   = 1'b0;
        alu_en   = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;
        hlt      = 1'b0;
        case (r_state)
            T1: begin
                pc_en    = 1'b1;
                mar_load = 1'b1;
            end
            T2: pc_inc = 1'b1;
            T3: begin
                mem_en  = 1'b1;
                ir_load = 1'b1;
            end
            T4: begin
                case (w_op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ir_en    = 1'b1;
                        mar_load = 1'b1;
                    end
                    OP_OUT: begin
                        a_en     = 1'b1;
                        out_load = 1'b1;
                    end
                    OP_HLT:  hlt = 1'b1;
                    default: ;
                endcase
            end
            T5: begin
                case (w_op)
                    OP_LDA: begin
                        mem_en = 1'b1;
                        a_load = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        mem_en = 1'b1;
                        b_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (w_op == OP_ADD || w_op == OP_SUB) begin
                    alu_en  = 1'b1;
                    a_load  = 1'b1;
                    alu_sub = (w_op == OP_SUB);
                end
            end
            HALT:    hlt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: unit sequences plus a full SAP-1 program.
// Honours SEQ_EARLY_END_EN for cycle-count expectations.
module tb_instr_sequencer;

    localparam logic [12:0] S_PCEN  = 13'h1000;
    localparam logic [12:0] S_PCINC = 13'h0800;
    localparam logic [12:0] S_MARLD = 13'h0400;
    localparam logic [12:0] S_MEMEN = 13'h0200;
    localparam logic [12:0] S_IRLD  = 13'h0100;
    localparam logic [12:0] S_IREN  = 13'h0080;
    localparam logic [12:0] S_ALD   = 13'h0040;
    localparam logic [12:0] S_AEN   = 13'h0020;
    localparam logic [12:0] S_BLD   = 13'h0010;
    localparam logic [12:0] S_ALUEN = 13'h0008;
    localparam logic [12:0] S_SUB   = 13'h0004;
    localparam logic [12:0] S_OUTLD = 13'h0002;
    localparam logic [12:0] S_HLT   = 13'h0001;

    logic       clk;
    logic       rst;
    logic [7:0] bus;
    logic [7:0] ir_out;
    logic [3:0] opcode;
    logic [2:0] tstate;
    logic pc_en, pc_inc, mar_load, mem_en, ir_load, ir_en;
    logic a_load, a_en, b_load, alu_en, alu_sub, out_load, hlt;
    logic [12:0] strobes;

    logic       sys_mode;
    logic [7:0] tb_bus;
    logic [7:0] sys_bus;
    logic [3:0] pc;
    logic [3:0] mar;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rout;
    logic [7:0] mem [16];

    int checks;
    int failures;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ir_out(ir_out), .opcode(opcode), .tstate(tstate),
        .pc_en(pc_en), .pc_inc(pc_inc), .mar_load(mar_load),
        .mem_en(mem_en), .ir_load(ir_load), .ir_en(ir_en),
        .a_load(a_load), .a_en(a_en), .b_load(b_load),
        .alu_en(alu_en), .alu_sub(alu_sub), .out_load(out_load),
        .hlt(hlt)
    );

    assign strobes = {pc_en, pc_inc, mar_load, mem_en, ir_load, ir_en,
                      a_load, a_en, b_load, alu_en, alu_sub, out_load, hlt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        sys_bus = 8'h00;
        if (pc_en)  sys_bus = sys_bus | {4'h0, pc};
        if (mem_en) sys_bus = sys_bus | mem[mar];
        if (ir_en)  sys_bus = sys_bus | ir_out;
        if (a_en)   sys_bus = sys_bus | ra;
        if (alu_en) sys_bus = sys_bus | (alu_sub ? ra - rb : ra + rb);
    end

    assign bus = sys_mode ? sys_bus : tb_bus;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc   <= 4'h0;
            mar  <= 4'h0;
            ra   <= 8'h00;
            rb   <= 8'h00;
            rout <= 8'h00;
        end else if (sys_mode) begin
            if (pc_inc)   pc   <= pc + 4'h1;
            if (mar_load) mar  <= bus[3:0];
            if (a_load)   ra   <= bus;
            if (b_load)   rb   <= bus;
            if (out_load) rout <= bus;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [12:0] exp_sub [6];
    int cyc;

    initial begin
        checks   = 0;
        failures = 0;
        sys_mode = 1'b0;
        tb_bus   = 8'h00;
        rst      = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0]  = 8'h0D;
        mem[1]  = 8'h1E;
        mem[2]  = 8'h2F;
        mem[3]  = 8'hF0;
        mem[13] = 8'h03;
        mem[14] = 8'h04;
        mem[15] = 8'h02;
        exp_sub[0] = S_PCEN | S_MARLD;
        exp_sub[1] = S_PCINC;
        exp_sub[2] = S_MEMEN | S_IRLD;
        exp_sub[3] = S_IREN | S_MARLD;
        exp_sub[4] = S_MEMEN | S_BLD;
        exp_sub[5] = S_ALUEN | S_SUB | S_ALD;

        // reset held over three edges
        step(); step(); step();
        check("rst_tstate", 32'(tstate), 0);
        check("rst_irout", 32'(ir_out), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_strobes", 32'(strobes), 32'(S_PCEN | S_MARLD));
        rst = 1'b1;
        step();
        check("rel_tstate", 32'(tstate), 1);

        // LDA 0xD
        check("lda_t2", 32'(strobes), 32'(S_PCINC));
        step();
        check("lda_t3", 32'(strobes), 32'(S_MEMEN | S_IRLD));
        tb_bus = 8'h0D;
        step();
        tb_bus = 8'hAA;
        check("lda_t4_state", 32'(tstate), 3);
        check("lda_t4_op", 32'(opcode), 0);
        check("lda_t4_irout", 32'(ir_out), 32'h0D);
        check("lda_t4", 32'(strobes), 32'(S_IREN | S_MARLD));
        step();
        check("lda_t5", 32'(strobes), 32'(S_MEMEN | S_ALD));
`ifndef SEQ_EARLY_END_EN
        step();
        check("lda_t6_state", 32'(tstate), 5);
        check("lda_t6", 32'(strobes), 0);
`endif
        step();
        check("lda_end", 32'(tstate), 0);
        check("lda_ir_kept", 32'(ir_out), 32'h0D);

        // SUB 0xF, every state against the table
        for (int i = 0; i < 6; i++) begin
            check("sub_state", 32'(tstate), 32'(i));
            check("sub_strobes", 32'(strobes), 32'(exp_sub[i]));
            check("sub_alusub", 32'(alu_sub), (i == 5) ? 1 : 0);
            if (i == 2) tb_bus = 8'h2F;
            step();
            tb_bus = 8'h55;
        end
        check("sub_end", 32'(tstate), 0);

        // HLT then HALT
        step(); step();
        tb_bus = 8'hF0;
        step();
        check("hlt_t4_state", 32'(tstate), 3);
        check("hlt_t4", 32'(strobes), 32'(S_HLT));
        tb_bus = 8'h1E;
        step();
        for (int i = 0; i < 20; i++) begin
            check("halt_state", 32'(tstate), 6);
            check("halt_strobes", 32'(strobes), 32'(S_HLT));
            check("halt_opcode", 32'(opcode), 32'hF);
            step();
        end

        // async reset while halted
        #2 rst = 1'b0;
        #1;
        check("halt_rst_state", 32'(tstate), 0);
        check("halt_rst_ir", 32'(ir_out), 0);
        check("halt_rst_op", 32'(opcode), 0);
        #1 rst = 1'b1;
        step();
        check("halt_rel_state", 32'(tstate), 1);

        // ADD 0xE, reset in T5
        step();
        tb_bus = 8'h1E;
        step();
        tb_bus = 8'h00;
        step();
        check("add_t5_state", 32'(tstate), 4);
        check("add_t5", 32'(strobes), 32'(S_MEMEN | S_BLD));
        check("add_t5_op", 32'(opcode), 1);
        #2 rst = 1'b0;
        #1;
        check("add_rst_state", 32'(tstate), 0);
        check("add_rst_op", 32'(opcode), 0);
        check("add_rst_ir", 32'(ir_out), 0);
        #1 rst = 1'b1;

        // full program on the modelled datapath
        sys_mode = 1'b1;
        rst = 1'b0;
        step();
        rst = 1'b1;
        cyc = 0;
        while (tstate != 3'd6 && cyc < 60) begin
            check("one_driver",
                  32'($countones({pc_en, mem_en, ir_en, a_en, alu_en}) <= 1),
                  1);
            step();
            cyc++;
        end
        check("prog_halted", 32'(tstate), 6);
`ifdef SEQ_EARLY_END_EN
        check("prog_cycles", 32'(cyc), 21);
`else
        check("prog_cycles", 32'(cyc), 22);
`endif
        check("prog_a", 32'(ra), 32'h05);
        check("prog_b", 32'(rb), 32'h02);
        check("prog_pc", 32'(pc), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
